// File: rtl/mc_err_cnt_pkg.sv
// mc_err_cnt_pkg: shared channel state type and default geometry for mc_err_cnt
package mc_err_cnt_pkg;
  typedef enum logic [1:0] {ARM = 2'd0, WREF = 2'd1, RUN = 2'd2} chan_state_e;
  localparam int NCH_DEF   = 4;
  localparam int CNT_W_DEF = 12;
  localparam int DLY_DEF   = 1;
endpackage

// File: rtl/err_chan.sv
// err_chan: one compare channel (sampling, reference delay, lock FSM, error counter, overflow)
// MC_ERR_CNT_SAT_EN selects a saturating counter; otherwise the counter wraps.
module err_chan
  import mc_err_cnt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DLY   = DLY_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             crest_i,
  input  logic             rpg_i,
  output logic             cmp_o,
  output logic             locked_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic s1_q, s2_q, cmp_q, cmp_d, ovf_q, ovf_d, rd, inc, full;
  logic [DLY-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  chan_state_e state_q;
  assign rd   = rd_q[DLY-1];
  assign inc  = en_i & cmp_q;
  assign full = &cnt_q;
  always_comb begin
    cmp_d = ~clr_i & en_i & (state_q == RUN) & (s1_q ^ rd);
    ovf_d = ~clr_i & (ovf_q | (inc & full));
`ifdef MC_ERR_CNT_SAT_EN
    cnt_d = clr_i ? '0 : (inc & ~full) ? cnt_q + CNT_W'(1) : cnt_q;
`else
    cnt_d = clr_i ? '0 : inc ? cnt_q + CNT_W'(1) : cnt_q;
`endif
  end
  // Sampling and the reference delay line keep running while EN is low so no resync is needed.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      rd_q    <= '0;
      cmp_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= ARM;
    end else begin
      s1_q  <= crest_i;
      s2_q  <= s1_q;
      rd_q  <= DLY'({rd_q, rpg_i});
      cmp_q <= cmp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (clr_i) state_q <= ARM;
      else if (en_i)
        case (state_q)
          ARM:     if (s1_q && !s2_q) state_q <= WREF;
          WREF:    if (rd) state_q <= RUN;
          default: ;
        endcase
    end
  assign cmp_o    = cmp_q;
  assign locked_o = state_q == RUN;
  assign ovf_o    = ovf_q;
  assign cnt_o    = cnt_q;
endmodule

// File: rtl/mc_err_cnt.sv
// mc_err_cnt: NCH independent bit-compare channels with lock FSM and error counters
// MC_ERR_CNT_SAT_EN (in err_chan) makes the counters saturate instead of wrap.
module mc_err_cnt
  import mc_err_cnt_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DLY   = DLY_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic [NCH-1:0]       CREST_IN,
  input  logic [NCH-1:0]       RPG_IN,
  output logic [NCH-1:0]       CMP_OUT,
  output logic [NCH-1:0]       LOCKED,
  output logic [NCH*CNT_W-1:0] ERR_CNT,
  output logic [NCH-1:0]       OVF,
  output logic                 ERR_ANY
);
  logic err_any_q;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    err_chan #(.CNT_W(CNT_W), .DLY(DLY)) u_chan (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .en_i    (EN),
      .clr_i   (CLR),
      .crest_i (CREST_IN[i]),
      .rpg_i   (RPG_IN[i]),
      .cmp_o   (CMP_OUT[i]),
      .locked_o(LOCKED[i]),
      .ovf_o   (OVF[i]),
      .cnt_o   (ERR_CNT[i*CNT_W +: CNT_W])
    );
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) err_any_q <= 1'b0;
    else err_any_q <= |CMP_OUT;
  assign ERR_ANY = err_any_q;
endmodule
